// File: rtl/dw_clr_pkg.sv
// Shared types and helpers for the clear-handshake source controller.
package dw_clr_pkg;

    localparam int RETRY_W = 3;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ISSUE      = 3'd1,
        WAIT_PROG  = 3'd2,
        WAIT_CMPLT = 3'd3,
        DONE       = 3'd4,
        FAIL       = 3'd5
    } clr_state_t;

    // Timer width; counts 0..tmo-1, so clog2(tmo) bits suffice.
    function automatic int clr_cnt_w(input int tmo);
        return (tmo <= 2) ? 1 : $clog2(tmo);
    endfunction

endpackage

// File: rtl/dw_clr_tmo_timer.sv
// Wait-state timer: clear / increment, flags terminal count TMO_CYCLES-1.
module dw_clr_tmo_timer
    import dw_clr_pkg::*;
#(
    parameter int TMO_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CNT_W = clr_cnt_w(TMO_CYCLES);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == CNT_W'(TMO_CYCLES - 1));

endmodule

// File: rtl/dw_clr_initiator.sv
// Source-side clear-handshake controller: launches clr_s, tracks progress,
// retries on timeout and reports done / timeout / sticky err.
module dw_clr_initiator
    import dw_clr_pkg::*;
#(
    parameter int TMO_CYCLES = 1024,
    parameter int RETRY_MAX  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               init_n,
    input  logic               req,
    input  logic               clr_in_prog,
    input  logic               clr_cmplt,
    output logic               clr_s,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               err,
    output logic [RETRY_W-1:0] retry_cnt
);

    clr_state_t state;
    logic       pending;
    logic       srst_n;
    logic       tmr_clr;
    logic       tmr_inc;
    logic       tmr_tc;
    logic       retry_ok;

    assign srst_n   = rst_n && init_n;
    assign retry_ok = (retry_cnt < RETRY_W'(RETRY_MAX));

    // Timer restarts on launch and again when progress is seen.
    assign tmr_clr = (state == ISSUE) ||
                     (state == WAIT_PROG && !clr_cmplt && clr_in_prog);
    assign tmr_inc = (state == WAIT_PROG) || (state == WAIT_CMPLT);

    dw_clr_tmo_timer #(.TMO_CYCLES(TMO_CYCLES)) u_tmr (
        .clk   (clk),
        .rst_n (srst_n),
        .clr   (tmr_clr),
        .inc   (tmr_inc),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            retry_cnt <= '0;
            clr_s     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            err       <= 1'b0;
        end else begin
            clr_s   <= 1'b0;
            done    <= 1'b0;
            timeout <= 1'b0;
            if (req && state != IDLE)
                pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (req) begin
                        state     <= ISSUE;
                        clr_s     <= 1'b1;
                        busy      <= 1'b1;
                        err       <= 1'b0;
                        retry_cnt <= '0;
                    end
                end
                ISSUE: state <= WAIT_PROG;
                WAIT_PROG, WAIT_CMPLT: begin
                    // Completion wins over a coincident timeout.
                    if (clr_cmplt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (state == WAIT_PROG && clr_in_prog) begin
                        state <= WAIT_CMPLT;
                    end else if (tmr_tc) begin
                        if (retry_ok) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= ISSUE;
                            clr_s     <= 1'b1;
                        end else begin
                            state   <= FAIL;
                            timeout <= 1'b1;
                            err     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    pending <= 1'b0;
                    // A req landing in this very cycle counts as pending too.
                    if (pending || req) begin
                        state     <= ISSUE;
                        clr_s     <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                FAIL: begin
                    pending <= 1'b0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dw_clr_initiator.sv
// Bench for dw_clr_initiator: directed scenarios plus randomized handshake timelines.
module tb_dw_clr_initiator;

    localparam int TMO  = 8;
    localparam int RMAX = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_n = 1'b1;
    logic       req = 1'b0;
    logic       clr_in_prog = 1'b0;
    logic       clr_cmplt = 1'b0;
    logic       clr_s, busy, done, timeout, err;
    logic [2:0] retry_cnt;
    logic       clr_s0, busy0, done0, timeout0, err0;
    logic [2:0] retry_cnt0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dw_clr_initiator #(.TMO_CYCLES(TMO), .RETRY_MAX(RMAX)) dut (
        .clk(clk), .rst_n(rst_n), .init_n(init_n), .req(req),
        .clr_in_prog(clr_in_prog), .clr_cmplt(clr_cmplt),
        .clr_s(clr_s), .busy(busy), .done(done), .timeout(timeout),
        .err(err), .retry_cnt(retry_cnt)
    );

    // Same stimulus, no retries allowed.
    dw_clr_initiator #(.TMO_CYCLES(TMO), .RETRY_MAX(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .init_n(init_n), .req(req),
        .clr_in_prog(clr_in_prog), .clr_cmplt(clr_cmplt),
        .clr_s(clr_s0), .busy(busy0), .done(done0), .timeout(timeout0),
        .err(err0), .retry_cnt(retry_cnt0)
    );

    function automatic logic [7:0] obs();
        return {clr_s, busy, done, timeout, err, retry_cnt};
    endfunction

    function automatic logic [7:0] obs0();
        return {clr_s0, busy0, done0, timeout0, err0, retry_cnt0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; clr_cmplt = 1'b1;
        step(); step();
        n_chk++;
        if (obs() !== 8'h00) begin n_fail++; $display("FAIL reset_hold got=%b exp=%b", obs(), 8'h00); end
        n_chk++;
        if (obs0() !== 8'h00) begin n_fail++; $display("FAIL reset_hold0 got=%b exp=%b", obs0(), 8'h00); end
        rst_n = 1'b1; req = 1'b0; clr_cmplt = 1'b0;
        step();
        n_chk++;
        if (obs() !== 8'h00) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", obs(), 8'h00); end
    endtask

    task automatic test_nominal();
        logic [7:0] exp;
        for (int t = 0; t <= 16; t++) begin
            exp = {t == 6, t >= 6 && t <= 13, t == 13, 1'b0, 1'b0, 3'd0};
            n_chk++;
            if (obs() !== exp) begin n_fail++; $display("FAIL nominal t=%0d got=%b exp=%b", t, obs(), exp); end
            req = (t == 5); clr_in_prog = (t == 8); clr_cmplt = (t == 12);
            step();
        end
    endtask

    task automatic test_fast();
        logic [7:0] exp;
        for (int t = 0; t <= 5; t++) begin
            exp = {t == 1, t >= 1 && t <= 3, t == 3, 1'b0, 1'b0, 3'd0};
            n_chk++;
            if (obs() !== exp) begin n_fail++; $display("FAIL fast_path t=%0d got=%b exp=%b", t, obs(), exp); end
            req = (t == 0); clr_in_prog = 1'b0; clr_cmplt = (t == 2);
            step();
        end
    endtask

    task automatic test_retry();
        logic [7:0] exp, exp0;
        int r;
        for (int t = 0; t <= 38; t++) begin
            r = (t >= 19 && t <= 33) ? 2 : (t >= 10 && t < 19) ? 1 : 0;
            exp  = {t == 1 || t == 10 || t == 19 || t == 34,
                    (t >= 1 && t <= 28) || (t >= 34 && t <= 36),
                    t == 36, t == 28, t >= 28 && t <= 33, 3'(r)};
            exp0 = {t == 1 || t == 34,
                    (t >= 1 && t <= 10) || (t >= 34 && t <= 36),
                    t == 36, t == 10, t >= 10 && t <= 33, 3'd0};
            n_chk++;
            if (obs() !== exp) begin n_fail++; $display("FAIL retry t=%0d got=%b exp=%b", t, obs(), exp); end
            n_chk++;
            if (obs0() !== exp0) begin n_fail++; $display("FAIL retry_max0 t=%0d got=%b exp=%b", t, obs0(), exp0); end
            req = (t == 0 || t == 33); clr_in_prog = 1'b0; clr_cmplt = (t == 35);
            step();
        end
    endtask

    task automatic test_coalesce();
        logic [7:0] exp;
        for (int t = 0; t <= 18; t++) begin
            exp = {t == 1 || t == 11, t >= 1 && t <= 14, t == 10 || t == 14, 1'b0, 1'b0, 3'd0};
            n_chk++;
            if (obs() !== exp) begin n_fail++; $display("FAIL coalesce t=%0d got=%b exp=%b", t, obs(), exp); end
            req = (t == 0 || t == 4 || t == 6 || t == 7);
            clr_in_prog = (t == 2); clr_cmplt = (t == 9 || t == 13);
            step();
        end
    endtask

    task automatic test_reset_mid(input bit use_init);
        logic [7:0] exp;
        for (int t = 0; t <= 12; t++) begin
            exp = {t == 1, t >= 1 && t <= 4, 1'b0, 1'b0, 1'b0, 3'd0};
            n_chk++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL reset_mid(init=%0d) t=%0d got=%b exp=%b", use_init, t, obs(), exp);
            end
            req = (t == 0 || t == 3); clr_in_prog = (t == 6); clr_cmplt = (t == 7 || t == 9);
            rst_n = !(t == 4 && !use_init); init_n = !(t == 4 && use_init);
            step();
        end
        rst_n = 1'b1; init_n = 1'b1;
    endtask

    task automatic test_tiebreak();
        logic [7:0] exp;
        for (int t = 0; t <= 23; t++) begin
            exp = {t == 1 || t == 10, t >= 1 && t <= 20, t == 20, 1'b0, 1'b0, (t >= 10) ? 3'd1 : 3'd0};
            n_chk++;
            if (obs() !== exp) begin n_fail++; $display("FAIL tiebreak t=%0d got=%b exp=%b", t, obs(), exp); end
            req = (t == 0); clr_in_prog = (t == 11); clr_cmplt = (t == 19);
            step();
        end
    endtask

    // Each attempt: response offsets drawn at random; the outcome and cycle of
    // every pulse follow from the wait-window arithmetic alone.
    task automatic test_random(input int nseq);
        bit a_req[128], a_prog[128], a_cm[128], e_clr[128], e_done[128], e_tmo[128];
        int iss[$];
        int c, r, fin, p, q, rc, prev_retry;
        bit fast, ok, stop, er, prev_err;
        logic [7:0] exp;
        prev_retry = 1; prev_err = 1'b0;
        for (int s = 0; s < nseq; s++) begin
            for (int i = 0; i < 128; i++) begin
                a_req[i] = 0; a_prog[i] = 0; a_cm[i] = 0; e_clr[i] = 0; e_done[i] = 0; e_tmo[i] = 0;
            end
            iss.delete();
            c = 1; r = 0; ok = 0; stop = 0; fin = 0; a_req[0] = 1;
            while (!stop) begin
                iss.push_back(c); e_clr[c] = 1;
                p = $urandom_range(0, TMO + 1);
                q = $urandom_range(0, TMO + 1);
                fast = ($urandom_range(0, 2) == 0);
                if (p < TMO && fast) begin
                    a_cm[c+1+p] = 1; fin = c + 2 + p; ok = 1; stop = 1;
                end else if (p < TMO && q < TMO) begin
                    a_prog[c+1+p] = 1; a_cm[c+2+p+q] = 1; fin = c + 3 + p + q; ok = 1; stop = 1;
                end else begin
                    if (p < TMO) begin a_prog[c+1+p] = 1; c = c + 2 + p + TMO; end
                    else c = c + 1 + TMO;
                    if (r == RMAX) begin fin = c; stop = 1; end
                    else r++;
                end
            end
            if (ok) e_done[fin] = 1; else e_tmo[fin] = 1;
            for (int t = fin + 1; t <= fin + 2; t++) begin
                a_prog[t] = 1'($urandom_range(0, 1));
                a_cm[t]   = 1'($urandom_range(0, 1));
            end
            for (int t = 0; t <= fin + 3; t++) begin
                rc = -1;
                foreach (iss[i]) if (iss[i] <= t) rc++;
                if (t == 0) rc = prev_retry;
                er = (t == 0) ? prev_err : (t >= fin && !ok);
                exp = {e_clr[t], t >= 1 && t <= fin, e_done[t], e_tmo[t], er, 3'(rc)};
                n_chk++;
                if (obs() !== exp) begin
                    n_fail++;
                    $display("FAIL random seq=%0d t=%0d got=%b exp=%b", s, t, obs(), exp);
                end
                req = a_req[t]; clr_in_prog = a_prog[t]; clr_cmplt = a_cm[t];
                step();
            end
            prev_retry = r; prev_err = !ok;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_fast();
        test_retry();
        test_coalesce();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_tiebreak();
        test_random(25);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
